// File: rtl/axis_pfbsynth_ola.sv
// Overlap-add and output quantisation back end for the synthesis PFB:
// sums each beat's head half with the previous frame's tail, rounds, shifts and saturates.
module axis_pfbsynth_ola #(
  parameter int N    = 64,
  parameter int L    = 4,
  parameter int BIN  = 16,
  parameter int BOUT = 16
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic [2*L*2*BIN-1:0]   s_axis_tdata,
  input  logic                   s_axis_tlast,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  output logic [L*2*BOUT-1:0]    m_axis_tdata,
  output logic                   m_axis_tvalid,
  input  logic [31:0]            QOUT_REG,
  output logic [15:0]            err_cnt
);

  localparam int F    = N / L;
  localparam int CW   = (F > 1) ? $clog2(F) : 1;
  localparam int HW   = L * 2 * BIN;
  localparam int NC   = 2 * L;
  localparam int QMAX = BIN + 1 - BOUT + 7;
  // Wide enough for sum plus the largest rounding constant without overflow.
  localparam int SUMW = BIN + 9;

  localparam logic signed [SUMW-1:0] MAXV = {{(SUMW-BOUT+1){1'b0}}, {(BOUT-1){1'b1}}};
  localparam logic signed [SUMW-1:0] MINV = {{(SUMW-BOUT+1){1'b1}}, {(BOUT-1){1'b0}}};

  logic [CW-1:0]  cnt;
  logic           primed;
  logic [3:0]     q_lat;
  logic [3:0]     q_in;
  logic [3:0]     q_cur;
  logic           acc;
  logic           exp_last;

  logic           v1;
  logic [HW-1:0]  head1;
  logic [HW-1:0]  rd1;
  logic           primed1;
  logic [3:0]     q1;

  logic [HW-1:0]  mem [F];

  logic [L*2*BOUT-1:0]     q_data;
  logic signed [SUMW-1:0]  s_v;
  logic signed [SUMW-1:0]  p_v;
  logic signed [SUMW-1:0]  rnd_v;
  logic signed [SUMW-1:0]  sh_v;

  logic unused_qout;
  assign unused_qout = ^QOUT_REG[31:4];

  assign acc      = s_axis_tvalid && s_axis_tready;
  assign exp_last = (cnt == CW'(F - 1));

  always_comb begin
    if ({28'd0, QOUT_REG[3:0]} > 32'(QMAX)) q_in = 4'(QMAX);
    else                                    q_in = QOUT_REG[3:0];
    // The frame-start beat already uses the newly sampled shift.
    q_cur = (cnt == '0) ? q_in : q_lat;
  end

  // Framing, shift latch and error accounting.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cnt           <= '0;
      primed        <= 1'b0;
      q_lat         <= '0;
      err_cnt       <= '0;
      s_axis_tready <= 1'b0;
    end else begin
      s_axis_tready <= 1'b1;
      if (acc) begin
        cnt <= (s_axis_tlast || exp_last) ? '0 : cnt + CW'(1);
        if (cnt == '0) q_lat <= q_in;
        if (s_axis_tlast != exp_last) begin
          primed <= 1'b0;
          if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
        end else if (s_axis_tlast) begin
          primed <= 1'b1;
        end
      end
    end
  end

  // Overlap memory: read the previous tail, then overwrite it with this beat's tail.
  always_ff @(posedge aclk) begin
    if (acc) begin
      rd1      <= mem[cnt];
      mem[cnt] <= s_axis_tdata[2*HW-1:HW];
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      v1      <= 1'b0;
      head1   <= '0;
      primed1 <= 1'b0;
      q1      <= '0;
    end else begin
      v1 <= acc;
      if (acc) begin
        head1   <= s_axis_tdata[HW-1:0];
        primed1 <= primed;
        q1      <= q_cur;
      end
    end
  end

  always_comb begin
    q_data = '0;
    s_v    = '0;
    p_v    = '0;
    rnd_v  = '0;
    sh_v   = '0;
    for (int unsigned k = 0; k < NC; k++) begin
      s_v   = SUMW'($signed(head1[k*BIN +: BIN]));
      p_v   = primed1 ? SUMW'($signed(rd1[k*BIN +: BIN])) : '0;
      rnd_v = (q1 != 4'd0) ? (SUMW'(1) << (q1 - 4'd1)) : '0;
      s_v   = s_v + p_v + rnd_v;
      sh_v  = s_v >>> q1;
      if (sh_v > MAXV)      sh_v = MAXV;
      else if (sh_v < MINV) sh_v = MINV;
      q_data[k*BOUT +: BOUT] = sh_v[BOUT-1:0];
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
    end else begin
      m_axis_tvalid <= v1;
      if (v1) m_axis_tdata <= q_data;
    end
  end

endmodule

// File: tb/tb_axis_pfbsynth_ola.sv
// Scoreboard bench for axis_pfbsynth_ola with N=8, L=4 (two beats per frame), 16-bit samples.
module tb_axis_pfbsynth_ola;
  localparam int N = 8, L = 4, BIN = 16, BOUT = 16, F = 2, QMAX = 8;

  logic           aclk = 1'b0;
  logic           aresetn = 1'b0;
  logic [255:0]   s_axis_tdata = '0;
  logic           s_axis_tlast = 1'b0;
  logic           s_axis_tvalid = 1'b0;
  logic           s_axis_tready;
  logic [127:0]   m_axis_tdata;
  logic           m_axis_tvalid;
  logic [31:0]    QOUT_REG = '0;
  logic [15:0]    err_cnt;

  axis_pfbsynth_ola #(.N(N), .L(L), .BIN(BIN), .BOUT(BOUT)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tdata(s_axis_tdata), .s_axis_tlast(s_axis_tlast),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .QOUT_REG(QOUT_REG), .err_cnt(err_cnt)
  );

  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc++;

  typedef struct { logic [127:0] d; int oc; bit hh; int hand; } exp_t;
  exp_t sb[$];
  int checks = 0, failures = 0;

  int m_cnt, m_q, m_err;
  bit m_primed;
  int m_mem[F][L][2];

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic int sx16(input int v);
    logic signed [15:0] s;
    s = v[15:0];
    return int'(s);
  endfunction

  // Lane j: I = v^j, Q = ~(v^j); lane 0 I equals v itself.
  function automatic int comp(input int v, input int j, input int c);
    int x;
    x = v ^ j;
    if (c != 0) x = ~x;
    return sx16(x);
  endfunction

  function automatic logic [255:0] pack_in(input int h, input int t);
    logic [255:0] d;
    int x;
    d = '0;
    for (int j = 0; j < L; j++)
      for (int c = 0; c < 2; c++) begin
        x = comp(h, j, c);
        d[j*32 + c*16 +: 16] = x[15:0];
        x = comp(t, j, c);
        d[(L+j)*32 + c*16 +: 16] = x[15:0];
      end
    return d;
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_q = 0; m_err = 0; m_primed = 0;
    sb.delete();
  endtask

  task automatic model_beat(input int h, input int t, input bit last, input bit hh, input int hand);
    int qr, qe, hv, pv, s;
    bit el;
    exp_t e;
    qr = int'(QOUT_REG[3:0]);
    qe = (m_cnt == 0) ? ((qr > QMAX) ? QMAX : qr) : m_q;
    if (m_cnt == 0) m_q = qe;
    e.d = '0;
    for (int j = 0; j < L; j++)
      for (int c = 0; c < 2; c++) begin
        hv = comp(h, j, c);
        pv = m_primed ? m_mem[m_cnt][j][c] : 0;
        s = hv + pv;
        if (qe > 0) s = s + (1 << (qe - 1));
        s = s >>> qe;
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        e.d[j*32 + c*16 +: 16] = s[15:0];
        m_mem[m_cnt][j][c] = comp(t, j, c);
      end
    el = (m_cnt == F - 1);
    if (last != el) begin
      m_err++;
      m_primed = 0;
    end else if (last) m_primed = 1;
    m_cnt = (last || el) ? 0 : m_cnt + 1;
    e.oc = cyc + 2;
    e.hh = hh;
    e.hand = hand;
    sb.push_back(e);
  endtask

  // Called at posedge+1; the beat is accepted on the next rising edge.
  task automatic beat(input int h, input int t, input bit last, input bit hh = 0, input int hand = 0);
    s_axis_tdata  = pack_in(h, t);
    s_axis_tlast  = last;
    s_axis_tvalid = 1'b1;
    model_beat(h, t, last, hh, hand);
    @(posedge aclk); #1;
  endtask

  task automatic idle(input int n);
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    repeat (n) begin @(posedge aclk); #1; end
  endtask

  task automatic frame(input int h, input int t, input int hand);
    beat(h, t, 0, 1, hand);
    beat(h, t, 1, 1, hand);
  endtask

  task automatic rframe(input int h, input int t, input bit hh, input int hand);
    beat(h, t, 0, hh, hand);
    idle($urandom_range(0, 2));
    beat(h, t, 1, hh, hand);
    idle($urandom_range(0, 2));
  endtask

  always @(negedge aclk) begin
    if (aresetn && m_axis_tvalid) begin
      if (sb.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_out actual=%h required=none", m_axis_tdata);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checks++;
        if (m_axis_tdata !== e.d || cyc != e.oc) begin
          failures++;
          $display("FAIL data actual=%h@%0d required=%h@%0d", m_axis_tdata, cyc, e.d, e.oc);
        end
        if (e.hh) chk("lane0_i", sx16(int'(m_axis_tdata[15:0])), e.hand);
      end
    end
  end

  initial begin
    model_reset();
    repeat (3) begin @(posedge aclk); #1; end
    chk("rst_tvalid", int'(m_axis_tvalid), 0);
    chk("rst_tdata", int'(m_axis_tdata != '0), 0);
    chk("rst_err", int'(err_cnt), 0);
    chk("rst_tready", int'(s_axis_tready), 0);
    aresetn = 1'b1;
    @(posedge aclk); #1;
    chk("tready_up", int'(s_axis_tready), 1);

    // Three clean frames: first without overlap, then 100+100.
    frame(100, 100, 100);
    frame(100, 100, 200);
    frame(100, 100, 200);
    idle(3);
    chk("err_clean", int'(err_cnt), 0);

    // Saturation both ways, rounding, and shift clamp.
    frame(0, 32767, 100);
    frame(32767, -32768, 32767);
    frame(-32768, 0, -32768);
    QOUT_REG = 32'd1;
    frame(3, 0, 2);
    QOUT_REG = 32'd15;
    frame(25600, 0, 100);

    // Shift change mid-frame only applies from the next frame start.
    QOUT_REG = 32'd0;
    beat(5, 0, 0, 1, 5);
    QOUT_REG = 32'd1;
    beat(5, 0, 1, 1, 5);
    frame(5, 0, 3);
    QOUT_REG = 32'd0;

    // Early tlast at cnt=0.
    beat(10, 7, 1, 1, 10);
    chk("err_early", int'(err_cnt), 1);
    frame(10, 7, 10);
    frame(10, 7, 17);
    chk("err_after_early", int'(err_cnt), 1);

    // Missing tlast at the last beat.
    beat(1, 2, 0, 1, 8);
    beat(1, 2, 0, 1, 8);
    chk("err_missing", int'(err_cnt), 2);
    frame(1, 2, 1);
    frame(1, 2, 3);

    // tlast on an idle cycle is ignored.
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b1;
    @(posedge aclk); #1;
    idle(1);
    frame(1, 2, 3);
    chk("err_idle_tlast", int'(err_cnt), 2);
    chk("err_model", int'(err_cnt), m_err);

    // Mid-frame reset with gaps.
    beat(1, 2, 0);
    idle(1);
    beat(4, 4, 1);
    beat(9, 9, 0);
    aresetn = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast = 1'b0;
    model_reset();
    #2;
    chk("midrst_tvalid", int'(m_axis_tvalid), 0);
    chk("midrst_err", int'(err_cnt), 0);
    chk("midrst_tready", int'(s_axis_tready), 0);
    @(posedge aclk); #1;
    aresetn = 1'b1;
    idle(2);
    rframe(40, 9, 1, 40);
    rframe(40, 9, 1, 49);
    repeat (4) rframe(int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)), 0, 0);
    chk("err_after_rst", int'(err_cnt), 0);

    idle(1);
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge aclk);
    #1;
    chk("drain", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axis_pfbsynth_ola.md
# axis_pfbsynth_ola

Parametrised overlap-add and output-quantisation stage for the synthesis PFB family. It generalises the fixed 4-lane/64-channel, 50 %-overlap back end to any lane count L, channel count N and sample width. It adds frame-sync checking on `s_axis_tlast`, per-frame latching of the quantisation shift, rounding with saturation, and an error counter. It sits between the IFFT/filter stage (input, 2L samples per beat) and the DAC-side stream (output, L samples per beat).

## Interface
- `N`, 64, channels per frame; power of 2, N ≥ 2L.
- `L`, 4, output lanes; power of 2.
- `BIN`, 16, input bits per I or Q component.
- `BOUT`, 16, output bits per I or Q component; BOUT ≤ BIN+1.
- `aclk`  in  1  single clock for everything.
- `aresetn`  in  1  asynchronous, active-low reset.
- `s_axis_tdata`  in  2L·2·BIN  samples 0..L-1 are "head", samples L..2L-1 are "tail"; each sample is {Q,I}, with I in the low half.
- `s_axis_tlast`  in  1  marks the last beat of a frame.
- `s_axis_tvalid`  in  1  input beat valid.
- `s_axis_tready`  out  1  always accepting once out of reset.
- `m_axis_tdata`  out  L·2·BOUT  overlap-added, quantised samples, {Q,I} per lane.
- `m_axis_tvalid`  out  1  output beat valid.
- `QOUT_REG`  in  32  quantisation right-shift; bits [3:0] are used, values above BIN+1-BOUT+7 clamp to that value.
- `err_cnt`  out  16  count of framing errors; saturates at 0xFFFF.

## Operation
- Frame length: F = N/L beats. Beat counter `cnt` runs 0..F-1 and advances only on accepted beats (`tvalid`).
- Overlap memory: F words × L × 2·BIN, storing the tail half of each beat.
  - Beat k reads address k, which holds the previous frame's tail k.
  - The same beat then writes its own tail to address k (read-before-write).
- Sum per component: head(k) + prev_tail(k), sign-extended to BIN+1 bits.
  - prev_tail is forced to 0 while `primed` = 0.
- Quantise per component:
  - Add 2^(q-1) when q > 0 (round half up), using the latched shift q.
  - Arithmetic shift right by q.
  - Saturate to BOUT bits: [-2^(BOUT-1), 2^(BOUT-1)-1].
- QOUT latch: `QOUT_REG[3:0]` is sampled into q on the beat with `cnt`=0. The value is clamped at that point and held for the whole frame.
- Framing:
  - `exp_last` = (`cnt` = F-1).
  - Next `cnt` = 0 if `tlast` or `exp_last`, otherwise `cnt`+1.
  - `err` = `tlast` XOR `exp_last`, evaluated on accepted beats only.
  - On `err`: `primed` ← 0 and `err_cnt` increments (saturating).
  - On `tlast` with `exp_last` (clean frame end): `primed` ← 1.
- Error recovery: output is never suppressed. After an error, the next full frame is emitted without the overlap contribution, and normal overlap-add resumes on the frame after that.
- Reset values:
  - `cnt` = 0, `primed` = 0, q = 0, `err_cnt` = 0.
  - `s_axis_tready` = 0 while in reset, 1 from the first clock edge after reset release.
  - `m_axis_tvalid` = 0, `m_axis_tdata` = 0.
  - Memory contents are not reset; `primed` masks them.

## Timing
- Latency is 2 cycles from input beat to output beat.
  - Stage 1: memory read and head register.
  - Stage 2: add, round, saturate, output register.
- `m_axis_tvalid` is `s_axis_tvalid` delayed by 2 cycles. Gaps in the input are reproduced exactly in the output.
- No output backpressure exists. The downstream consumer must accept every beat.
- Throughput is one beat per cycle. Back-to-back frames need no idle cycles: with continuous `tvalid`, the memory read at beat k sees the write from the previous frame's beat k.
- A QOUT change mid-frame takes effect on the next beat with `cnt`=0. A frame is never quantised with mixed shifts.
- Reset asserted mid-frame clears all state immediately. `m_axis_tvalid` falls asynchronously, and in-flight beats are discarded.
- `tlast` on an idle cycle (`tvalid`=0) is ignored.

## Test plan
- N=8, L=4 (F=2), QOUT=0, ramp input (head = tail = 100 per lane, one I/Q pair) for 3 clean frames → frame 1 outputs I=100; frames 2–3 output I=200. `tvalid` is 2 cycles after input; `err_cnt`=0.
- Saturation and rounding, BIN=BOUT=16: head=0x7FFF, tail=0x7FFF, primed, QOUT=0 → output 0x7FFF. With QOUT=1, head=3, prev_tail=0 → output 2 (rounded half up). With head=-32768, prev_tail=-32768, QOUT=0 → output -32768.
- `tlast` early on `cnt`=0 → `err_cnt`=1, `cnt` restarts. The next frame is output with tail contribution 0, and the frame after that is overlap-added again.
- `tlast` missing at `cnt`=F-1 → `err_cnt` increments once, `cnt` wraps to 0, `primed` cleared.
- `QOUT_REG` written 0→1 at `cnt`=1 → the rest of the current frame still uses shift 0; the next frame uses shift 1.
- `aresetn` low for 1 cycle mid-frame with random `tvalid` gaps → `m_axis_tvalid`=0 immediately and `err_cnt`=0. The first frame after reset is output without overlap; later frames match the reference model.
